bcd_digit_counter: RTL and testbench

//  Multi-digit BCD up/down counter with clock-enable prescaler and a digit-scan multiplexer.

---
 rtl/bcd_digit_counter_if.sv | 26 ++
 rtl/bcd_digit_counter.sv | 132 +++++++++++++
 tb/tb_bcd_digit_counter.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_digit_counter_if.sv
// Control/status bundle of the BCD digit counter: count controls in,
// count value, status pulses and display-scan outputs back.
interface bcd_digit_counter_if #(
    parameter int N_DIGITS = 2
);
    logic                    en;
    logic                    up;
    logic                    clear;
    logic                    load;
    logic [4*N_DIGITS-1:0]   load_val;
    logic [4*N_DIGITS-1:0]   bcd;
    logic                    co;
    logic                    load_err;
    logic [3:0]              digit_a;
    logic [N_DIGITS-1:0]     scan_sel;

    modport master (
        output en, up, clear, load, load_val,
        input  bcd, co, load_err, digit_a, scan_sel
    );

    modport slave (
        input  en, up, clear, load, load_val,
        output bcd, co, load_err, digit_a, scan_sel
    );
endinterface

// File: rtl/bcd_digit_counter.sv
// Multi-digit BCD up/down counter with enable prescaler, parallel load and a
// free-running digit-scan multiplexer feeding a downstream decimal decoder.
module bcd_digit_counter #(
    parameter int N_DIGITS = 2,
    parameter int PRESCALE = 4,
    parameter int SCAN_DIV = 3
) (
    input logic               clk,
    input logic               rst_n,
    bcd_digit_counter_if.slave bus
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST  = PW'(PRESCALE - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam int BW = 4 * N_DIGITS;

    logic [BW-1:0]       bcd_q, bcd_d, cnt_val;
    logic [PW-1:0]       pre_q, pre_d;
    logic [SW-1:0]       scan_cnt_q, scan_cnt_d;
    logic [N_DIGITS-1:0] sel_q, sel_d;
    logic [3:0]          digit_q, digit_d;
    logic                co_q, co_d;
    logic                err_q, err_d;
    logic                load_ok;
    logic                carry;
    logic                cnt_wrap;
    logic                scan_step;

    // NOTE: every always_comb output is given a default before any branch so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        load_ok = 1'b1;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (bus.load_val[4*i +: 4] > 4'd9) load_ok = 1'b0;
        end
    end

    // Ripple carry/borrow through the digits; the carry out of the top digit
    // is the wrap indication.
    always_comb begin
        cnt_val = bcd_q;
        carry   = 1'b1;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (carry) begin
                if (bus.up) begin
                    if (bcd_q[4*i +: 4] >= 4'd9) begin
                        cnt_val[4*i +: 4] = 4'd0;
                    end else begin
                        cnt_val[4*i +: 4] = bcd_q[4*i +: 4] + 4'd1;
                        carry             = 1'b0;
                    end
                end else begin
                    if (bcd_q[4*i +: 4] == 4'd0) begin
                        cnt_val[4*i +: 4] = 4'd9;
                    end else begin
                        cnt_val[4*i +: 4] = bcd_q[4*i +: 4] - 4'd1;
                        carry             = 1'b0;
                    end
                end
            end
        end
        cnt_wrap = carry;
    end

    always_comb begin
        bcd_d = bcd_q;
        pre_d = pre_q;
        co_d  = 1'b0;
        err_d = 1'b0;
        if (bus.clear) begin
            bcd_d = '0;
            pre_d = '0;
        end else if (bus.load) begin
            // A rejected load leaves count and prescaler untouched.
            if (load_ok) begin
                bcd_d = bus.load_val;
                pre_d = '0;
            end else begin
                err_d = 1'b1;
            end
        end else if (bus.en) begin
            if (pre_q == PRE_LAST) begin
                pre_d = '0;
                bcd_d = cnt_val;
                co_d  = cnt_wrap;
            end else begin
                pre_d = pre_q + 1'b1;
            end
        end
    end

    // The scanned digit is taken from the post-update count so a tick and a
    // scan step on the same edge never show a stale digit.
    always_comb begin
        scan_step  = (scan_cnt_q == SCAN_LAST);
        scan_cnt_d = scan_step ? '0 : scan_cnt_q + 1'b1;
        sel_d      = scan_step ? ((sel_q << 1) | (sel_q >> (N_DIGITS - 1))) : sel_q;
        digit_d    = 4'd0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (sel_d[i]) digit_d = bcd_d[4*i +: 4];
        end
    end

    // NOTE: registers are updated with non-blocking assignments so every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_q      <= '0;
            pre_q      <= '0;
            co_q       <= 1'b0;
            err_q      <= 1'b0;
            scan_cnt_q <= '0;
            sel_q      <= N_DIGITS'(1);
            digit_q    <= 4'd0;
        end else begin
            bcd_q      <= bcd_d;
            pre_q      <= pre_d;
            co_q       <= co_d;
            err_q      <= err_d;
            scan_cnt_q <= scan_cnt_d;
            sel_q      <= sel_d;
            digit_q    <= digit_d;
        end
    end

    assign bus.bcd      = bcd_q;
    assign bus.co       = co_q;
    assign bus.load_err = err_q;
    assign bus.scan_sel = sel_q;
    assign bus.digit_a  = digit_q;
endmodule

// File: tb/tb_bcd_digit_counter.sv
// Scoreboard bench: a decimal-integer model predicts each cycle's outputs,
// pushes them to a queue, and they are popped and compared after the edge.
module tb_bcd_digit_counter;
    localparam int N    = 2;
    localparam int PRE  = 4;
    localparam int SDIV = 3;
    localparam int MOD  = 100;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    bcd_digit_counter_if #(.N_DIGITS(N)) bus ();

    bcd_digit_counter #(
        .N_DIGITS(N),
        .PRESCALE(PRE),
        .SCAN_DIV(SDIV)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct packed {
        logic [4*N-1:0] bcd;
        logic           co;
        logic           err;
        logic [N-1:0]   sel;
        logic [3:0]     digit;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad   = 0;
    int m_val, m_pre, m_scnt, m_idx;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [4*N-1:0] to_bcd(input int v);
        logic [4*N-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic [3:0] digit_of(input int v, input int idx);
        for (int i = 0; i < idx; i++) v = v / 10;
        return 4'(v % 10);
    endfunction

    task automatic model_reset();
        m_val  = 0;
        m_pre  = 0;
        m_scnt = 0;
        m_idx  = 0;
    endtask

    task automatic predict();
        exp_t e;
        int   lv;
        logic ok;
        logic [3:0] nib;
        e = '0;
        if (bus.clear) begin
            m_val = 0;
            m_pre = 0;
        end else if (bus.load) begin
            ok = 1'b1;
            lv = 0;
            for (int i = N - 1; i >= 0; i--) begin
                nib = bus.load_val[4*i +: 4];
                if (nib > 4'd9) ok = 1'b0;
                lv = lv * 10 + int'(nib);
            end
            if (ok) begin
                m_val = lv;
                m_pre = 0;
            end else begin
                e.err = 1'b1;
            end
        end else if (bus.en) begin
            if (m_pre == PRE - 1) begin
                m_pre = 0;
                if (bus.up) begin
                    if (m_val == MOD - 1) begin m_val = 0; e.co = 1'b1; end
                    else m_val = m_val + 1;
                end else begin
                    if (m_val == 0) begin m_val = MOD - 1; e.co = 1'b1; end
                    else m_val = m_val - 1;
                end
            end else begin
                m_pre = m_pre + 1;
            end
        end
        if (m_scnt == SDIV - 1) begin
            m_scnt = 0;
            m_idx  = (m_idx + 1) % N;
        end else begin
            m_scnt = m_scnt + 1;
        end
        e.bcd        = to_bcd(m_val);
        e.sel[m_idx] = 1'b1;
        e.digit      = digit_of(m_val, m_idx);
        sb.push_back(e);
    endtask

    task automatic step();
        exp_t e;
        predict();
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check("bcd",      32'(bus.bcd),      32'(e.bcd));
            check("co",       32'(bus.co),       32'(e.co));
            check("load_err", 32'(bus.load_err), 32'(e.err));
            check("scan_sel", 32'(bus.scan_sel), 32'(e.sel));
            check("digit_a",  32'(bus.digit_a),  32'(e.digit));
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic check_reset_state(input string pfx);
        check({pfx, "_bcd"},      32'(bus.bcd),      32'd0);
        check({pfx, "_co"},       32'(bus.co),       32'd0);
        check({pfx, "_load_err"}, 32'(bus.load_err), 32'd0);
        check({pfx, "_scan_sel"}, 32'(bus.scan_sel), 32'd1);
        check({pfx, "_digit_a"},  32'(bus.digit_a),  32'd0);
    endtask

    task automatic do_load(input logic [4*N-1:0] v);
        bus.load     = 1'b1;
        bus.load_val = v;
        step();
        bus.load     = 1'b0;
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.en       = 1'b0;
        bus.up       = 1'b1;
        bus.clear    = 1'b0;
        bus.load     = 1'b0;
        bus.load_val = '0;
        model_reset();
        #12;
        check_reset_state("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Count up from 00 through 09 to 10.
        bus.en = 1'b1;
        bus.up = 1'b1;
        run(40);
        check("up_reach_10", 32'(bus.bcd), 32'h10);

        // 99 -> 00 with carry.
        do_load(8'h99);
        run(4);
        check("up_wrap_co", 32'(bus.co), 32'd1);
        run(1);

        // Down: 00 -> 99 with borrow, 10 -> 09.
        bus.up = 1'b0;
        do_load(8'h00);
        run(4);
        check("down_wrap_99", 32'(bus.bcd), 32'h99);
        do_load(8'h10);
        run(4);
        check("down_10_09", 32'(bus.bcd), 32'h09);

        // en low for two cycles mid-period delays the tick by two cycles.
        run(2);
        bus.en = 1'b0;
        run(2);
        bus.en = 1'b1;
        run(1);
        check("en_hold_no_tick", 32'(bus.bcd), 32'h09);
        run(1);
        check("en_hold_tick", 32'(bus.bcd), 32'h08);

        // Load, rejected load, clear-over-load.
        bus.en = 1'b0;
        do_load(8'h47);
        check("load_47", 32'(bus.bcd), 32'h47);
        do_load(8'h4A);
        check("load_bad_err", 32'(bus.load_err), 32'd1);
        run(2);
        bus.clear = 1'b1;
        do_load(8'h47);
        bus.clear = 1'b0;
        check("clear_over_load", 32'(bus.bcd), 32'h00);

        // Scan with 47 held.
        do_load(8'h47);
        run(12);

        // Tick and scan step coinciding around 19 -> 20.
        bus.up = 1'b1;
        do_load(8'h19);
        bus.en = 1'b1;
        run(16);

        // Asynchronous reset mid-count, between clock edges.
        run(6);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("async_rst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        run(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
